// File: rtl/vga_pkg.sv
// ============================================================================
//  Module      : vga_pkg
//  Description : 640x480@60 timing constants, control/colour types and the
//                optional colour-bar helper (VGA_SCAN_TESTPATTERN_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package vga_pkg;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 10;

  localparam logic [CNT_W-1:0] H_VISIBLE = CNT_W'(640);
  localparam logic [CNT_W-1:0] H_FP      = CNT_W'(16);
  localparam logic [CNT_W-1:0] H_SYNC    = CNT_W'(96);
  localparam logic [CNT_W-1:0] H_BP      = CNT_W'(48);
  localparam logic [CNT_W-1:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam logic [CNT_W-1:0] V_VISIBLE = CNT_W'(480);
  localparam logic [CNT_W-1:0] V_FP      = CNT_W'(10);
  localparam logic [CNT_W-1:0] V_SYNC    = CNT_W'(2);
  localparam logic [CNT_W-1:0] V_BP      = CNT_W'(33);
  localparam logic [CNT_W-1:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Sync windows are half-open: [START, END)
  localparam logic [CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [CNT_W-1:0] H_LAST       = H_TOTAL - CNT_W'(1);
  localparam logic [CNT_W-1:0] V_LAST       = V_TOTAL - CNT_W'(1);

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
  } vga_ctl_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic vga_ctl_t decode_ctl(input logic [CNT_W-1:0] hc,
                                          input logic [CNT_W-1:0] vc);
    vga_ctl_t ctl;
    ctl.hs_n    = !((hc >= H_SYNC_START) && (hc < H_SYNC_END));
    ctl.vs_n    = !((vc >= V_SYNC_START) && (vc < V_SYNC_END));
    ctl.blank_n = (hc < H_VISIBLE) && (vc < V_VISIBLE);
    return ctl;
  endfunction

`ifdef VGA_SCAN_TESTPATTERN_EN
  localparam logic [CNT_W-1:0] BAR_WIDTH = CNT_W'(80);

  // Bar index n maps its three bits straight onto full-scale R, G, B
  function automatic rgb_t bar_colour(input logic [CNT_W-1:0] hc);
    logic [2:0] bar;
    rgb_t       c;
    bar = 3'(hc / BAR_WIDTH);
    c.r = {8{bar[2]}};
    c.g = {8{bar[1]}};
    c.b = {8{bar[0]}};
    return c;
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/vga_sync_counter.sv
// ============================================================================
//  Module      : vga_sync_counter
//  Description : Half-rate pixel enable plus horizontal/vertical scan counters
//                and the one-cycle frame-start pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_sync_counter
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_hc,
  output logic [CNT_W-1:0] o_vc,
  output logic             o_frame_start
);

  logic             r_tick;
  logic [CNT_W-1:0] r_hc;
  logic [CNT_W-1:0] r_vc;
  logic             r_frame;
  logic             w_h_last;
  logic             w_v_last;

  assign w_h_last = (r_hc == H_LAST);
  assign w_v_last = (r_vc == V_LAST);

  // Frame pulse is set on the wrap tick, so it is high while (hc,vc)=(0,0)
  // and cleared on the following edge, which never advances the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick  <= 1'b0;
      r_hc    <= '0;
      r_vc    <= '0;
      r_frame <= 1'b0;
    end else begin
      r_tick  <= ~r_tick;
      r_frame <= 1'b0;
      if (r_tick) begin
        if (w_h_last) begin
          r_hc <= '0;
          if (w_v_last) begin
            r_vc    <= '0;
            r_frame <= 1'b1;
          end else begin
            r_vc <= r_vc + CNT_W'(1);
          end
        end else begin
          r_hc <= r_hc + CNT_W'(1);
        end
      end
    end
  end

  assign o_tick        = r_tick;
  assign o_hc          = r_hc;
  assign o_vc          = r_vc;
  assign o_frame_start = r_frame;

endmodule

`default_nettype wire

// File: rtl/vga_scan_driver.sv
// ============================================================================
//  Module      : vga_scan_driver
//  Description : 640x480 VGA scan driver: scan coordinates out, registered
//                sync/blank/colour to the DAC. Define VGA_SCAN_TESTPATTERN_EN
//                to add a test_mode input selecting built-in colour bars.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_scan_driver
  import vga_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [7:0]         Red,
  input  logic [7:0]         Green,
  input  logic [7:0]         Blue,
`ifdef VGA_SCAN_TESTPATTERN_EN
  input  logic               test_mode,
`endif
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               pix_tick,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic               frame_start
);

  logic             w_tick;
  logic [CNT_W-1:0] w_hc;
  logic [CNT_W-1:0] w_vc;
  vga_ctl_t         w_ctl;
  rgb_t             w_rgb;
  vga_ctl_t         r_ctl;
  rgb_t             r_rgb;

  vga_sync_counter u_cnt (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .o_tick        (w_tick),
    .o_hc          (w_hc),
    .o_vc          (w_vc),
    .o_frame_start (frame_start)
  );

  assign w_ctl = decode_ctl(w_hc, w_vc);

  always_comb begin
    w_rgb.r = Red;
    w_rgb.g = Green;
    w_rgb.b = Blue;
`ifdef VGA_SCAN_TESTPATTERN_EN
    if (test_mode) begin
      w_rgb = bar_colour(w_hc);
    end
`endif
    if (!w_ctl.blank_n) begin
      w_rgb = '0;
    end
  end

  // Single output stage: everything here lags DrawX/DrawY by one pixel
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ctl.hs_n    <= 1'b1;
      r_ctl.vs_n    <= 1'b1;
      r_ctl.blank_n <= 1'b0;
      r_rgb         <= '0;
    end else if (w_tick) begin
      r_ctl <= w_ctl;
      r_rgb <= w_rgb;
    end
  end

  assign DrawX       = {{(COORD_W-CNT_W){1'b0}}, w_hc};
  assign DrawY       = {{(COORD_W-CNT_W){1'b0}}, w_vc};
  assign pix_tick    = w_tick;
  assign VGA_CLK     = w_tick;
  assign VGA_HS      = r_ctl.hs_n;
  assign VGA_VS      = r_ctl.vs_n;
  assign VGA_BLANK_N = r_ctl.blank_n;
  assign VGA_R       = r_rgb.r;
  assign VGA_G       = r_rgb.g;
  assign VGA_B       = r_rgb.b;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_driver.sv
// ============================================================================
//  Module      : tb_vga_scan_driver
//  Description : Self-checking bench for vga_scan_driver against a linear
//                pixel-index model of the 800x525 scan.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_scan_driver;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [7:0]  Red = 8'h00;
  logic [7:0]  Green = 8'h00;
  logic [7:0]  Blue = 8'h00;
  logic [10:0] DrawX;
  logic [10:0] DrawY;
  logic        pix_tick;
  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        frame_start;
`ifdef VGA_SCAN_TESTPATTERN_EN
  logic        test_mode = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Model: m_p is the linear pixel index (vc*800 + hc) of the current scan position
  int         m_p;
  bit         m_tick;
  bit         m_hs_n;
  bit         m_vs_n;
  bit         m_blank_n;
  bit         m_fs;
  logic [7:0] m_r;
  logic [7:0] m_g;
  logic [7:0] m_b;
  int         mode;
  logic [9:0] f_hc;
  logic [9:0] f_vc;

  vga_scan_driver dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
`ifdef VGA_SCAN_TESTPATTERN_EN
    .test_mode   (test_mode),
`endif
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pix_tick    (pix_tick),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .frame_start (frame_start)
  );

  always #10 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_tick = 0; m_hs_n = 1; m_vs_n = 1; m_blank_n = 0; m_fs = 0;
    m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
  endtask

  task automatic check_all();
    chk("DrawX", 32'(DrawX), 32'(m_p % 800));
    chk("DrawY", 32'(DrawY), 32'(m_p / 800));
    chk("pix_tick", 32'(pix_tick), 32'(m_tick));
    chk("VGA_CLK", 32'(VGA_CLK), 32'(m_tick));
    chk("VGA_HS", 32'(VGA_HS), 32'(m_hs_n));
    chk("VGA_VS", 32'(VGA_VS), 32'(m_vs_n));
    chk("VGA_BLANK_N", 32'(VGA_BLANK_N), 32'(m_blank_n));
    chk("VGA_R", 32'(VGA_R), 32'(m_r));
    chk("VGA_G", 32'(VGA_G), 32'(m_g));
    chk("VGA_B", 32'(VGA_B), 32'(m_b));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic drive_inputs();
    Green = 8'($urandom);
    Blue  = 8'($urandom);
    case (mode)
      1:       Red = 8'(m_p % 800);
      2:       Red = 8'hAA;
      default: Red = 8'($urandom);
    endcase
  endtask

  // One Clk edge: advance the model from the scan rules, then compare
  task automatic step();
    int hx;
    int vy;
    int bar;
    @(posedge Clk);
    if (Reset_n !== 1'b1) begin
      model_reset();
    end else begin
      m_fs = 0;
      if (m_tick) begin
        hx = m_p % 800;
        vy = m_p / 800;
        m_hs_n    = !(hx >= 656 && hx <= 751);
        m_vs_n    = !(vy == 490 || vy == 491);
        m_blank_n = (hx < 640) && (vy < 480);
        m_r = Red; m_g = Green; m_b = Blue;
`ifdef VGA_SCAN_TESTPATTERN_EN
        if (test_mode) begin
          bar = hx / 80;
          m_r = ((bar & 4) != 0) ? 8'hFF : 8'h00;
          m_g = ((bar & 2) != 0) ? 8'hFF : 8'h00;
          m_b = ((bar & 1) != 0) ? 8'hFF : 8'h00;
        end
`endif
        if (!m_blank_n) begin
          m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
        end
        m_p  = (m_p + 1) % 420000;
        m_fs = (m_p == 0);
      end
      m_tick = !m_tick;
    end
    #1;
    check_all();
    drive_inputs();
  endtask

  // Move the scan position between edges to reach distant lines quickly
  task automatic jump(input int vy, input int hx);
    f_hc = 10'(hx);
    f_vc = 10'(vy);
    #1;
    force dut.u_cnt.r_hc = f_hc;
    force dut.u_cnt.r_vc = f_vc;
    #1;
    release dut.u_cnt.r_hc;
    release dut.u_cnt.r_vc;
    m_p = vy * 800 + hx;
  endtask

  initial begin
    int hs_cnt;
    int hs_x;
    int wraps;
    int prevx;
    int vs_cnt;
    int fs_cnt;
    int fs_x;
    int fs_y;
    int bad;
    bit found;

    mode = 0;
    model_reset();
    repeat (4) step();

    // Line 0 after reset release: one hc wrap, HS low for 96 ticks
    #5 Reset_n = 1'b1;
    hs_cnt = 0; hs_x = -1; wraps = 0; prevx = 0;
    for (int i = 0; i < 1600; i++) begin
      step();
      if (VGA_HS === 1'b0) begin
        if (hs_cnt == 0) hs_x = int'(DrawX);
        hs_cnt++;
      end
      if (DrawX == 11'd0 && prevx != 0) wraps++;
      prevx = int'(DrawX);
    end
    chk("hc_wraps_in_1600", 32'(wraps), 32'd1);
    chk("vc_after_1600", 32'(DrawY), 32'd1);
    chk("hs_low_clks", 32'(hs_cnt), 32'd192);
    chk("hs_first_drawx", 32'(hs_x), 32'd657);

    mode = 1;
    drive_inputs();
    repeat (1600) step();

    mode = 2;
    drive_inputs();
    bad = 0;
    for (int i = 0; i < 1600; i++) begin
      step();
      if (VGA_BLANK_N === 1'b1 && VGA_R !== 8'hAA) bad++;
      if (VGA_BLANK_N === 1'b0 && VGA_R !== 8'h00) bad++;
    end
    chk("blank_red_gating", 32'(bad), 32'd0);

    // Vertical sync window
    mode = 0;
    jump(488, 0);
    vs_cnt = 0;
    for (int i = 0; i < 8000; i++) begin
      step();
      if (VGA_VS === 1'b0) vs_cnt++;
    end
    chk("vs_low_clks", 32'(vs_cnt), 32'd3200);

    // Frame wrap
    jump(524, 790);
    fs_cnt = 0; fs_x = -1; fs_y = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (frame_start === 1'b1) begin
        fs_cnt++; fs_x = int'(DrawX); fs_y = int'(DrawY);
      end
    end
    chk("frame_start_pulses", 32'(fs_cnt), 32'd1);
    chk("frame_start_x", 32'(fs_x), 32'd0);
    chk("frame_start_y", 32'(fs_y), 32'd0);

    // Asynchronous reset mid-frame
    jump(300, 390);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (DrawX == 11'd400 && DrawY == 11'd300) found = 1;
    end
    chk("reach_400_300", 32'(found), 32'd1);
    #5 Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) step();
    #5 Reset_n = 1'b1;
    step();
    chk("restart_x", 32'(DrawX), 32'd0);
    chk("restart_y", 32'(DrawY), 32'd0);
    fs_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      step();
      if (frame_start === 1'b1) fs_cnt++;
    end
    chk("no_pulse_after_restart", 32'(fs_cnt), 32'd0);

`ifdef VGA_SCAN_TESTPATTERN_EN
    test_mode = 1'b1;
    jump(5, 0);
    found = 0;
    for (int i = 0; i < 1600; i++) begin
      step();
      if (DrawY == 11'd5 && DrawX == 11'd86 && !found) begin
        found = 1;
        chk("bar_hc85", {8'h00, VGA_R, VGA_G, VGA_B}, 32'h000000FF);
      end
      if (DrawY == 11'd5 && DrawX == 11'd640 && pix_tick === 1'b0) begin
        chk("bar_hc639", {8'h00, VGA_R, VGA_G, VGA_B}, 32'h00FFFFFF);
      end
    end
    test_mode = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
